// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_pkg
//  Description : Shared constants for the Clause-22 MDIO responder.
//                - frame field codes (start, opcodes)
//                - field widths
//                - responder FSM state encoding
//                - per-field bit-count limits
//  Revision    : 1.0  initial release
// ============================================================================
package mdio_pkg;

    // Frame field codes
    localparam logic [1:0] MDIO_ST     = 2'b01;
    localparam logic [1:0] MDIO_OP_RD  = 2'b10;
    localparam logic [1:0] MDIO_OP_WR  = 2'b01;

    // Field widths
    localparam int c_phyad_w = 5;
    localparam int c_regad_w = 5;
    localparam int c_data_w  = 16;

    // Responder FSM state encoding
    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_st2    = 3'd1;
    localparam logic [2:0] c_st_op     = 3'd2;
    localparam logic [2:0] c_st_phyad  = 3'd3;
    localparam logic [2:0] c_st_regad  = 3'd4;
    localparam logic [2:0] c_st_ta     = 3'd5;
    localparam logic [2:0] c_st_data   = 3'd6;
    localparam logic [2:0] c_st_skip   = 3'd7;

    // Value of the bit counter on the last bit of each field
    localparam logic [4:0] c_op_last   = 5'd1;
    localparam logic [4:0] c_addr_last = 5'd4;
    localparam logic [4:0] c_ta_last   = 5'd1;
    localparam logic [4:0] c_data_last = 5'd15;

    // SKIP counts down to zero. Bits still owed by the frame after the
    // rejecting field: PHYAD+REGAD+TA+DATA = 28, or REGAD+TA+DATA = 23.
    localparam logic [4:0] c_skip_from_op  = 5'd27;
    localparam logic [4:0] c_skip_from_phy = 5'd22;

endpackage
`default_nettype wire

// File: rtl/mdio_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_edge_sync
//  Description : Brings MDC and MDIO into the i_clk domain through equal-depth
//                flop chains and flags each MDC rising edge.
//  Ports       : i_clk, i_reset  - system clock / sync active-high reset
//                i_mdc, i_mdio   - asynchronous management clock / data
//                o_mdc_rise      - 1-cycle pulse on synchronised MDC 0->1
//                o_mdio_s        - synchronised MDIO, aligned with o_mdc_rise
//  Revision    : 1.0  initial release
// ============================================================================
module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_mdc,
    input  logic i_mdio,
    output logic o_mdc_rise,
    output logic o_mdio_s
);

    logic [SYNC_STAGES-1:0] r_mdc_sync;
    logic [SYNC_STAGES-1:0] r_mdio_sync;
    logic                   r_mdc_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mdc_sync  <= '0;
            r_mdio_sync <= '0;
            r_mdc_prev  <= 1'b0;
        end else begin
            r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], i_mdc};
            r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], i_mdio};
            r_mdc_prev  <= r_mdc_sync[SYNC_STAGES-1];
        end
    end

    // MDIO is stable around the MDC rise, so equal chain depths keep the
    // sampled data aligned with the edge pulse.
    assign o_mdc_rise = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_prev;
    assign o_mdio_s   = r_mdio_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mdio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_responder
//  Description : PHY-side Clause-22 MDIO responder. Decodes preamble, ST, OP,
//                PHYAD and REGAD from oversampled MDC/MDIO, turns reads and
//                writes into strobes on a local register port and drives the
//                read turnaround/data back onto io_mdio (MSB first).
//  Ports       : i_clk, i_reset  - system clock / sync active-high reset
//                i_mdc           - management clock (async)
//                io_mdio         - management data (driven only for reads)
//                o_reg_addr      - REGAD of the current frame
//                o_reg_rd        - 1-cycle read request
//                i_reg_rdata     - read data, captured 1 cycle after o_reg_rd
//                o_reg_wr        - 1-cycle write commit
//                o_reg_wdata     - write data, held until the next write
//                o_busy          - frame in progress (ST seen .. frame end)
//  Revision    : 1.0  initial release
// ============================================================================
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR    = 5'd1,
    parameter int         PRE_LEN     = 32,
    parameter bit         BCAST_EN    = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mdc,
    inout  wire         io_mdio,
    output logic [4:0]  o_reg_addr,
    output logic        o_reg_rd,
    input  logic [15:0] i_reg_rdata,
    output logic        o_reg_wr,
    output logic [15:0] o_reg_wdata,
    output logic        o_busy
);

    localparam logic [5:0] c_pre_len = 6'(PRE_LEN);

    logic                 w_mdc_rise;
    logic                 w_mdio_s;

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;
    logic [4:0]           r_cnt;
    logic [5:0]           r_pre_cnt;
    logic [15:0]          r_shift;
    logic                 r_is_rd;
    logic                 r_rd_lat;
    logic [4:0]           r_reg_addr;
    logic                 r_reg_rd;
    logic                 r_reg_wr;
    logic [15:0]          r_reg_wdata;

    logic [4:0]           w_field;
    logic [1:0]           w_op;
    logic                 w_op_ok;
    logic                 w_phy_ok;
    logic                 w_oe;
    logic                 w_mdo;

    mdio_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_mdc      (i_mdc),
        .i_mdio     (io_mdio),
        .o_mdc_rise (w_mdc_rise),
        .o_mdio_s   (w_mdio_s)
    );

    // Field value including the bit being sampled on this rise
    assign w_field  = {r_shift[3:0], w_mdio_s};
    assign w_op     = w_field[1:0];
    assign w_op_ok  = (w_op == MDIO_OP_RD) || (w_op == MDIO_OP_WR);
    // Broadcast address only counts for writes
    assign w_phy_ok = (w_field == PHY_ADDR) ||
                      (BCAST_EN && (w_field == 5'd0) && !r_is_rd);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (moves only on an MDC rise)
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_mdc_rise) begin
            case (r_state)
                c_st_idle:  if (!w_mdio_s && (r_pre_cnt == c_pre_len))
                                w_next_state = c_st_st2;
                c_st_st2:   w_next_state = w_mdio_s ? c_st_op : c_st_idle;
                c_st_op:    if (r_cnt == c_op_last)
                                w_next_state = w_op_ok ? c_st_phyad : c_st_skip;
                c_st_phyad: if (r_cnt == c_addr_last)
                                w_next_state = w_phy_ok ? c_st_regad : c_st_skip;
                c_st_regad: if (r_cnt == c_addr_last)
                                w_next_state = c_st_ta;
                c_st_ta:    if (r_cnt == c_ta_last)
                                w_next_state = c_st_data;
                c_st_data:  if (r_cnt == c_data_last)
                                w_next_state = c_st_idle;
                c_st_skip:  if (r_cnt == 5'd0)
                                w_next_state = c_st_idle;
                default:    w_next_state = c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters, shift register and register-port strobes
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_pre_cnt   <= '0;
            r_shift     <= '0;
            r_is_rd     <= 1'b0;
            r_rd_lat    <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_rd    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_reg_wdata <= '0;
        end else begin
            r_reg_rd <= 1'b0;
            r_reg_wr <= 1'b0;
            r_rd_lat <= r_reg_rd;

            // Read data arrives one cycle after the request; TA is still
            // at least one MDC period away.
            if (r_rd_lat) begin
                r_shift <= i_reg_rdata;
            end

            if (r_state != c_st_idle) begin
                r_pre_cnt <= '0;
            end

            if (w_mdc_rise) begin
                case (r_state)
                    c_st_idle: begin
                        r_cnt <= '0;
                        if (w_mdio_s) begin
                            if (r_pre_cnt != c_pre_len) begin
                                r_pre_cnt <= r_pre_cnt + 6'd1;
                            end
                        end else begin
                            r_pre_cnt <= '0;
                        end
                    end
                    c_st_st2: begin
                        r_cnt <= '0;
                    end
                    c_st_op: begin
                        r_shift <= {r_shift[14:0], w_mdio_s};
                        if (r_cnt == c_op_last) begin
                            r_is_rd <= (w_op == MDIO_OP_RD);
                            r_cnt   <= w_op_ok ? 5'd0 : c_skip_from_op;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    c_st_phyad: begin
                        r_shift <= {r_shift[14:0], w_mdio_s};
                        if (r_cnt == c_addr_last) begin
                            r_cnt <= w_phy_ok ? 5'd0 : c_skip_from_phy;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    c_st_regad: begin
                        r_shift <= {r_shift[14:0], w_mdio_s};
                        if (r_cnt == c_addr_last) begin
                            r_reg_addr <= w_field;
                            r_reg_rd   <= r_is_rd;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    c_st_ta: begin
                        r_cnt <= (r_cnt == c_ta_last) ? 5'd0 : r_cnt + 5'd1;
                    end
                    c_st_data: begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_is_rd) begin
                            // Present the next bit for the master's next rise
                            r_shift <= {r_shift[14:0], 1'b0};
                        end else begin
                            r_shift <= {r_shift[14:0], w_mdio_s};
                            if (r_cnt == c_data_last) begin
                                r_reg_wdata <= {r_shift[14:0], w_mdio_s};
                                r_reg_wr    <= 1'b1;
                            end
                        end
                    end
                    c_st_skip: begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus is driven from the rise that samples TA bit 1 until the
    // rise that samples the last data bit.
    // ------------------------------------------------------------------
    always_comb begin
        w_oe   = 1'b0;
        w_mdo  = 1'b0;
        o_busy = (r_state != c_st_idle);
        if (r_is_rd) begin
            if ((r_state == c_st_ta) && (r_cnt == c_ta_last)) begin
                w_oe = 1'b1;
            end else if (r_state == c_st_data) begin
                w_oe  = 1'b1;
                w_mdo = r_shift[15];
            end
        end
    end

    assign io_mdio     = w_oe ? w_mdo : 1'bz;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_rd    = r_reg_rd;
    assign o_reg_wr    = r_reg_wr;
    assign o_reg_wdata = r_reg_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mdio_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mdio_responder
//  Description : Self-checking bench for mdio_responder. Acts as the MDIO
//                master (MDC period = 10 i_clk) and as the register bank.
//                Instance A: PHY_ADDR=1, broadcast enabled.
//                Instance B: PHY_ADDR=2, broadcast disabled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdio_responder;

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc;
    logic        mdo_en;
    logic        mdo;
    wire         mdio_a;
    wire         mdio_b;

    logic [4:0]  addr_a, addr_b;
    logic        rd_a, rd_b, wr_a, wr_b, busy_a, busy_b;
    logic [15:0] rdata_a, rdata_b, wdata_a, wdata_b;

    int          n_vec = 0;
    int          n_err = 0;
    int          both_cnt = 0;
    int          b_strobes = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic        bus_q[$];

    always #5 clk = ~clk;

    assign mdio_a = mdo_en ? mdo : 1'bz;
    assign mdio_b = mdo_en ? mdo : 1'bz;
    pullup (mdio_a);
    pullup (mdio_b);

    mdio_responder #(.PHY_ADDR(5'd1), .PRE_LEN(32), .BCAST_EN(1'b1), .SYNC_STAGES(2)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_mdc(mdc), .io_mdio(mdio_a),
        .o_reg_addr(addr_a), .o_reg_rd(rd_a), .i_reg_rdata(rdata_a),
        .o_reg_wr(wr_a), .o_reg_wdata(wdata_a), .o_busy(busy_a)
    );

    mdio_responder #(.PHY_ADDR(5'd2), .PRE_LEN(32), .BCAST_EN(1'b0), .SYNC_STAGES(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_mdc(mdc), .io_mdio(mdio_b),
        .o_reg_addr(addr_b), .o_reg_rd(rd_b), .i_reg_rdata(rdata_b),
        .o_reg_wr(wr_b), .o_reg_wdata(wdata_b), .o_busy(busy_b)
    );

    function automatic logic [15:0] bank_val(input logic [4:0] a);
        return (a == 5'd3) ? 16'hA5C3 : {a, ~a, a, 1'b0};
    endfunction

    // Register bank: data valid only in the cycle after the request
    always @(posedge clk) begin
        rdata_a <= rd_a ? bank_val(addr_a) : 16'hDEAD;
        rdata_b <= rd_b ? bank_val(addr_b) : 16'hDEAD;
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (rd_a) obs_q.push_back({1'b0, addr_a, 16'h0000});
        if (wr_a) obs_q.push_back({1'b1, addr_a, wdata_a});
        if (rd_a && wr_a) both_cnt++;
        if (rd_b || wr_b) b_strobes++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One MDC period; master samples the bus just before the rising edge
    task automatic bit_cyc(input logic en, input logic v, output logic samp);
        mdo_en = en;
        mdo    = v;
        mdc    = 1'b0;
        #50;
        samp   = mdio_a;
        mdc    = 1'b1;
        #50;
    endtask

    task automatic drv(input logic v);
        logic s;
        bit_cyc(1'b1, v, s);
    endtask

    task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] rg, input logic [15:0] wd,
                              input logic resp, input logic busy_exp, input int n_data);
        logic        s;
        logic        e;
        logic [15:0] d;
        d = bank_val(rg);
        if (resp) exp_q.push_back({(op == 2'b01), rg, (op == 2'b01) ? wd : 16'h0000});
        for (int i = 0; i < pre; i++) drv(1'b1);
        drv(1'b0);
        drv(1'b1);
        drv(op[1]);
        drv(op[0]);
        for (int i = 4; i >= 0; i--) drv(phy[i]);
        for (int i = 4; i >= 0; i--) drv(rg[i]);
        chk("busy_mid_frame", busy_a, busy_exp);
        if (op == 2'b10) begin
            bus_q.push_back(1'b1);
            bus_q.push_back(resp ? 1'b0 : 1'b1);
            for (int i = 0; i < n_data; i++) bus_q.push_back(resp ? d[15-i] : 1'b1);
            for (int i = 0; i < 2 + n_data; i++) begin
                bit_cyc(1'b0, 1'b0, s);
                e = bus_q.pop_front();
                chk($sformatf("bus_bit%0d", i), s, e);
            end
            if (n_data == 16) begin
                bit_cyc(1'b0, 1'b0, s);
                chk("bus_released", s, 1'b1);
            end
        end else begin
            drv(1'b1);
            drv(1'b0);
            for (int i = 15; i >= 16 - n_data; i--) drv(wd[i]);
        end
    endtask

    task automatic check_events();
        logic s;
        ev_t  o;
        ev_t  x;
        bit_cyc(1'b0, 1'b0, s);
        bit_cyc(1'b0, 1'b0, s);
        chk("event_count", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            chk("event", {10'h0, o}, {10'h0, x});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst    = 1'b1;
        mdc    = 1'b0;
        mdo_en = 1'b0;
        mdo    = 1'b0;
        #40;
        rst    = 1'b0;
        #20;
        // Reset state
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_rd", rd_a, 1'b0);
        chk("rst_wr", wr_a, 1'b0);
        chk("rst_addr", addr_a, 5'd0);
        chk("rst_wdata", wdata_a, 16'h0000);
        chk("rst_bus", mdio_a, 1'b1);

        // Basic read
        send_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 1'b1, 1'b1, 16);
        check_events();

        // Basic write
        send_frame(32, 2'b01, 5'd1, 5'd31, 16'h1234, 1'b1, 1'b1, 16);
        check_events();
        chk("wdata_held", wdata_a, 16'h1234);

        // Address mismatch, then immediate valid read
        send_frame(32, 2'b10, 5'd5, 5'd3, 16'h0000, 1'b0, 1'b1, 16);
        check_events();
        send_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 1'b1, 1'b1, 16);
        check_events();

        // Short preamble: clear the idle ones counted so far, then 31 ones
        drv(1'b0);
        send_frame(31, 2'b01, 5'd1, 5'd5, 16'h0F0F, 1'b0, 1'b0, 16);
        check_events();

        // Bad opcode, then a normal frame
        send_frame(32, 2'b11, 5'd1, 5'd3, 16'h5555, 1'b0, 1'b1, 16);
        check_events();
        send_frame(32, 2'b10, 5'd1, 5'd4, 16'h0000, 1'b1, 1'b1, 16);
        check_events();

        // Broadcast
        send_frame(32, 2'b01, 5'd0, 5'd7, 16'hBEEF, 1'b1, 1'b1, 16);
        check_events();
        chk("bcast_wdata", wdata_a, 16'hBEEF);
        chk("b_no_bcast_wr", b_strobes, 0);
        send_frame(32, 2'b10, 5'd0, 5'd3, 16'h0000, 1'b0, 1'b1, 16);
        check_events();
        chk("b_no_bcast_rd", b_strobes, 0);
        send_frame(32, 2'b01, 5'd2, 5'd9, 16'h6789, 1'b0, 1'b1, 16);
        check_events();
        chk("b_own_wr", b_strobes, 1);
        chk("b_own_wdata", wdata_b, 16'h6789);
        chk("a_wdata_kept", wdata_a, 16'hBEEF);

        // Reset during read data: DUT now drives data bit 6 (0)
        send_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 1'b1, 1'b1, 6);
        #40;
        chk("pre_rst_bus", mdio_a, 1'b0);
        rst = 1'b1;
        #10;
        rst = 1'b0;
        chk("rst_mid_bus", mdio_a, 1'b1);
        chk("rst_mid_busy", busy_a, 1'b0);
        check_events();
        send_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 1'b1, 1'b1, 16);
        check_events();

        chk("rd_wr_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
